// File: rtl/ysyx_23060025_axi_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060025_axi_rd_arbiter_pkg
// Description : Shared types and constants for the two-master AXI4 read
//               arbiter: FSM state encoding and grant index values.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060025_axi_rd_arbiter_pkg;

  // Arbiter FSM states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  // Grant index: which master currently owns the DRAM read port.
  localparam logic c_gnt_m0 = 1'b0;  // icache refill
  localparam logic c_gnt_m1 = 1'b1;  // LSU / dcache load

endpackage : ysyx_23060025_axi_rd_arbiter_pkg
`default_nettype wire

// File: rtl/ysyx_23060025_axi_rd_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060025_axi_rd_arbiter_arb_pick
// Description : Combinational 2-way request picker.
//               YSYX_23060025_ARB_RR_EN defined : round-robin, on a tie the
//                                                master != rr_last wins.
//               YSYX_23060025_ARB_RR_EN undefined: fixed priority, M1 wins.
// Ports       : req[1:0] (in)  request vector, bit N = master N
//               rr_last  (in)  master served by the previous burst
//               gnt      (out) selected master index (valid when |req)
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060025_axi_rd_arbiter_arb_pick
  import ysyx_23060025_axi_rd_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       gnt
);

`ifdef YSYX_23060025_ARB_RR_EN
  always_comb begin
    gnt = c_gnt_m1;
    if (req == 2'b11) begin
      gnt = ~rr_last;
    end else if (req[0]) begin
      gnt = c_gnt_m0;
    end
  end
`else
  // In fixed-priority mode only req[1] matters; rr_last is kept upstream.
  logic w_unused;
  assign w_unused = rr_last ^ req[0];

  always_comb begin
    gnt = req[1] ? c_gnt_m1 : c_gnt_m0;
  end
`endif

endmodule : ysyx_23060025_axi_rd_arbiter_arb_pick
`default_nettype wire

// File: rtl/ysyx_23060025_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060025_axi_rd_arbiter
// Description : Shares one AXI4 read port toward DRAM between two burst read
//               masters (M0 = icache refill, M1 = LSU/dcache load). One grant
//               per transaction, held from AR handshake to the rlast beat.
//               Beats are counted against arlen; disagreements set the sticky
//               err_beat flag. Tie-break policy selected by the macro
//               YSYX_23060025_ARB_RR_EN (see arb_pick).
// Ports       : clock, reset_n (async, active-low)
//               m0_ar*/m1_ar* in, mN_arready out   : master address channels
//               mN_r* out, mN_rready in              : master read channels
//               out_ar* out, out_arready in          : DRAM address channel
//               out_r* in, out_rready out            : DRAM read channel
//               err_beat out                         : sticky beat-count error
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060025_axi_rd_arbiter
  import ysyx_23060025_axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  // master 0
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic                  m0_arvalid,
  input  logic [7:0]            m0_arlen,
  input  logic [2:0]            m0_arsize,
  input  logic [1:0]            m0_arburst,
  output logic                  m0_arready,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  input  logic                  m0_rready,
  // master 1
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic                  m1_arvalid,
  input  logic [7:0]            m1_arlen,
  input  logic [2:0]            m1_arsize,
  input  logic [1:0]            m1_arburst,
  output logic                  m1_arready,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  input  logic                  m1_rready,
  // DRAM side
  output logic [ADDR_WIDTH-1:0] out_araddr,
  output logic                  out_arvalid,
  output logic [7:0]            out_arlen,
  output logic [2:0]            out_arsize,
  output logic [1:0]            out_arburst,
  input  logic                  out_arready,
  input  logic                  out_rvalid,
  input  logic [DATA_WIDTH-1:0] out_rdata,
  input  logic [1:0]            out_rresp,
  input  logic                  out_rlast,
  output logic                  out_rready,
  // status
  output logic                  err_beat
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_grant;
  logic       r_rr_last;
  logic [7:0] r_beat_cnt;
  logic       r_err_beat;

  logic       w_pick;
  logic       w_any_req;
  logic       w_ar_fire;
  logic       w_r_fire;
  logic       w_err_now;
  logic [7:0] w_gnt_arlen;

  assign w_any_req = m0_arvalid | m1_arvalid;

  ysyx_23060025_axi_rd_arbiter_arb_pick u_pick (
    .req     ({m1_arvalid, m0_arvalid}),
    .rr_last (r_rr_last),
    .gnt     (w_pick)
  );

  // Routing: everything is driven from the registered state, so an
  // asynchronous reset zeroes all outputs immediately.
  always_comb begin
    out_araddr  = '0;
    out_arvalid = 1'b0;
    out_arlen   = '0;
    out_arsize  = '0;
    out_arburst = '0;
    out_rready  = 1'b0;
    m0_arready  = 1'b0;
    m0_rvalid   = 1'b0;
    m0_rdata    = '0;
    m0_rresp    = '0;
    m0_rlast    = 1'b0;
    m1_arready  = 1'b0;
    m1_rvalid   = 1'b0;
    m1_rdata    = '0;
    m1_rresp    = '0;
    m1_rlast    = 1'b0;
    case (r_state)
      ARB_ADDR: begin
        if (r_grant == c_gnt_m1) begin
          out_araddr  = m1_araddr;
          out_arvalid = m1_arvalid;
          out_arlen   = m1_arlen;
          out_arsize  = m1_arsize;
          out_arburst = m1_arburst;
          m1_arready  = out_arready;
        end else begin
          out_araddr  = m0_araddr;
          out_arvalid = m0_arvalid;
          out_arlen   = m0_arlen;
          out_arsize  = m0_arsize;
          out_arburst = m0_arburst;
          m0_arready  = out_arready;
        end
      end
      ARB_DATA: begin
        if (r_grant == c_gnt_m1) begin
          out_rready = m1_rready;
          m1_rvalid  = out_rvalid;
          m1_rdata   = out_rdata;
          m1_rresp   = out_rresp;
          m1_rlast   = out_rlast;
        end else begin
          out_rready = m0_rready;
          m0_rvalid  = out_rvalid;
          m0_rdata   = out_rdata;
          m0_rresp   = out_rresp;
          m0_rlast   = out_rlast;
        end
      end
      default: ;
    endcase
  end

  assign w_gnt_arlen = (r_grant == c_gnt_m1) ? m1_arlen : m0_arlen;
  assign w_ar_fire   = out_arvalid & out_arready;
  assign w_r_fire    = out_rvalid & out_rready;

  // beat_cnt holds the beats still expected after the current one.
  assign w_err_now = (r_state == ARB_DATA) && w_r_fire &&
                     (out_rlast ? (r_beat_cnt != 8'd0) : (r_beat_cnt == 8'd0));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (w_any_req)             w_state_nxt = ARB_ADDR;
      ARB_ADDR: if (w_ar_fire)             w_state_nxt = ARB_DATA;
      ARB_DATA: if (w_r_fire && out_rlast) w_state_nxt = ARB_IDLE;
      default:                             w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARB_IDLE;
      r_grant    <= c_gnt_m1;
      r_rr_last  <= c_gnt_m1;
      r_beat_cnt <= 8'd0;
      r_err_beat <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB_IDLE && w_any_req) begin
        r_grant <= w_pick;
      end
      // The count stops at zero so an overlong burst does not wrap and
      // look like a fresh burst; the error is already latched by then.
      if (w_ar_fire) begin
        r_beat_cnt <= w_gnt_arlen;
      end else if (w_r_fire && r_beat_cnt != 8'd0) begin
        r_beat_cnt <= r_beat_cnt - 8'd1;
      end
      if (w_r_fire && out_rlast) begin
        r_rr_last <= r_grant;
      end
      if (w_err_now) begin
        r_err_beat <= 1'b1;
      end
    end
  end

  assign err_beat = r_err_beat;

endmodule : ysyx_23060025_axi_rd_arbiter
`default_nettype wire

// File: tb/tb_ysyx_23060025_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060025_axi_rd_arbiter
// Description : Self-checking bench for ysyx_23060025_axi_rd_arbiter.
//               Directed reset / async-reset-mid-burst sequence, then random
//               traffic from two masters and a DRAM model. A transaction-level
//               reference (one burst at a time, tie rule, sticky error) feeds
//               scoreboard queues; a monitor pops them on DUT handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060025_axi_rd_arbiter;

  localparam int NTX = 24;
`ifdef YSYX_23060025_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] m0_araddr, m1_araddr, out_araddr;
  logic        m0_arvalid, m1_arvalid, out_arvalid;
  logic [7:0]  m0_arlen, m1_arlen, out_arlen;
  logic [2:0]  m0_arsize, m1_arsize, out_arsize;
  logic [1:0]  m0_arburst, m1_arburst, out_arburst;
  logic        m0_arready, m1_arready, out_arready;
  logic        m0_rvalid, m1_rvalid, out_rvalid;
  logic [31:0] m0_rdata, m1_rdata, out_rdata;
  logic [1:0]  m0_rresp, m1_rresp, out_rresp;
  logic        m0_rlast, m1_rlast, out_rlast;
  logic        m0_rready, m1_rready, out_rready;
  logic        err_beat;

  ysyx_23060025_axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rready(m1_rready),
    .out_araddr(out_araddr), .out_arvalid(out_arvalid), .out_arlen(out_arlen),
    .out_arsize(out_arsize), .out_arburst(out_arburst), .out_arready(out_arready),
    .out_rvalid(out_rvalid), .out_rdata(out_rdata), .out_rresp(out_rresp),
    .out_rlast(out_rlast), .out_rready(out_rready),
    .err_beat(err_beat)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event with no expectation queued", name);
  endtask

  // DRAM content and burst shape are derived from the address:
  // addr[3:2] = 2 -> burst ends early, 3 -> one beat too many, else exact.
  function automatic logic [31:0] beat_data(input logic [31:0] a, input int i);
    return a ^ (32'(i) * 32'h0101_0101) ^ 32'h5A00_0000;
  endfunction

  function automatic int plan_beats(input logic [31:0] a, input logic [7:0] len);
    case (a[3:2])
      2'd2:    return (len == 8'd0) ? 1 : int'(len) / 2 + 1;
      2'd3:    return int'(len) + 2;
      default: return int'(len) + 1;
    endcase
  endfunction

  function automatic logic f_arvalid(input int m); return (m == 1) ? m1_arvalid : m0_arvalid; endfunction
  function automatic logic f_arready(input int m); return (m == 1) ? m1_arready : m0_arready; endfunction
  function automatic logic f_rvalid(input int m);  return (m == 1) ? m1_rvalid  : m0_rvalid;  endfunction
  function automatic logic f_rready(input int m);  return (m == 1) ? m1_rready  : m0_rready;  endfunction
  function automatic logic f_rlast(input int m);   return (m == 1) ? m1_rlast   : m0_rlast;   endfunction
  function automatic logic [1:0]  f_rresp(input int m); return (m == 1) ? m1_rresp : m0_rresp; endfunction
  function automatic logic [31:0] f_rdata(input int m); return (m == 1) ? m1_rdata : m0_rdata; endfunction

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        err;
  } ar_exp_t;
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  ar_exp_t q_ar[$];
  beat_t   q_b0[$];
  beat_t   q_b1[$];

  bit run = 1'b0;
  int issued[2];
  int gap[2];
  int done_cnt[2];

  // ---------------- reference model (transaction level) ----------------
  bit mb_busy = 1'b0, mb_ar_done = 1'b0, mb_rr_last = 1'b1, mb_err = 1'b0;
  int mb_owner = 0;
  bit sn_busy = 1'b0, sn_ar_done = 1'b0;
  int sn_owner = 0;

  initial begin : p_model
    int w, nb;
    ar_exp_t e;
    beat_t b;
    forever begin
      @(negedge clock);
      if (run) begin
        sn_busy = mb_busy; sn_ar_done = mb_ar_done; sn_owner = mb_owner;
        if (!mb_busy) begin
          if (m0_arvalid || m1_arvalid) begin
            if (m0_arvalid && m1_arvalid) w = RR ? (mb_rr_last ? 0 : 1) : 1;
            else                          w = m1_arvalid ? 1 : 0;
            e.addr  = (w == 1) ? m1_araddr  : m0_araddr;
            e.len   = (w == 1) ? m1_arlen   : m0_arlen;
            e.size  = (w == 1) ? m1_arsize  : m0_arsize;
            e.burst = (w == 1) ? m1_arburst : m0_arburst;
            e.err   = mb_err;
            q_ar.push_back(e);
            nb = plan_beats(e.addr, e.len);
            for (int i = 0; i < nb; i++) begin
              b.data = beat_data(e.addr, i);
              b.resp = e.addr[5:4];
              b.last = (i == nb - 1);
              if (w == 1) q_b1.push_back(b); else q_b0.push_back(b);
            end
            if (nb != int'(e.len) + 1) mb_err = 1'b1;
            mb_busy = 1'b1; mb_ar_done = 1'b0; mb_owner = w;
          end
        end else if (!mb_ar_done) begin
          if (f_arvalid(mb_owner) && out_arready) mb_ar_done = 1'b1;
        end else if (out_rvalid && f_rready(mb_owner) && out_rlast) begin
          mb_busy = 1'b0;
          mb_rr_last = (mb_owner == 1);
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : p_monitor
    int o, l;
    ar_exp_t e;
    beat_t b;
    forever begin
      @(negedge clock); #1;
      if (run) begin
        if (!sn_busy) begin
          check("idle_quiet", {out_arvalid, out_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}, 64'd0);
        end else begin
          o = sn_owner; l = 1 - o;
          check("loser_quiet", {f_arready(l), f_rvalid(l), f_rlast(l), f_rdata(l)}, 64'd0);
          if (!sn_ar_done) begin
            check("addr_phase_fwd", {out_arvalid, out_rready, f_rvalid(o)}, {f_arvalid(o), 2'b00});
            if (out_arvalid && out_arready) begin
              if (q_ar.size() == 0) fail_now("ar_unexpected");
              else begin
                e = q_ar.pop_front();
                check("ar_fields", {out_araddr, out_arlen, out_arsize, out_arburst},
                      {e.addr, e.len, e.size, e.burst});
                check("ar_ready_fwd", f_arready(o), 64'd1);
                check("err_before_burst", err_beat, e.err);
              end
            end
          end else begin
            check("data_phase_fwd", {out_rready, out_arvalid}, {f_rready(o), 1'b0});
            if (f_rvalid(o) && f_rready(o)) begin
              if ((o == 1 ? q_b1.size() : q_b0.size()) == 0) fail_now("beat_unexpected");
              else begin
                b = (o == 1) ? q_b1.pop_front() : q_b0.pop_front();
                check("beat", {f_rdata(o), f_rresp(o), f_rlast(o)}, {b.data, b.resp, b.last});
                if (b.last) done_cnt[o]++;
              end
            end
          end
        end
      end
    end
  end

  // ---------------- random master + DRAM driver ----------------
  task automatic drive_master(input int m, input bit hs);
    logic [31:0] a;
    logic [7:0]  len;
    logic [1:0]  mode;
    int r;
    if (hs) begin
      if (m == 1) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
      gap[m] = int'($urandom % 4);
    end else if (!f_arvalid(m)) begin
      if (gap[m] > 0) gap[m]--;
      else if (issued[m] < NTX) begin
        a = $urandom;
        r = int'($urandom % 8);
        if (issued[m] >= NTX / 2 && r == 0)      mode = 2'd2;
        else if (issued[m] >= NTX / 2 && r == 1) mode = 2'd3;
        else                                     mode = 2'($urandom % 2);
        a[3:2] = mode;
        a[1:0] = 2'b00;
        len = 8'($urandom % 8);
        if (m == 1) begin m1_araddr = a; m1_arlen = len; m1_arvalid = 1'b1; end
        else        begin m0_araddr = a; m0_arlen = len; m0_arvalid = 1'b1; end
        issued[m]++;
      end
    end
  endtask

  bit          dr_busy = 1'b0;
  logic [31:0] dr_addr;
  int          dr_nb, dr_idx;

  initial begin : p_driver
    bit hs_ar0, hs_ar1, hs_dar, hs_r;
    logic [31:0] cap_addr;
    logic [7:0]  cap_len;
    forever begin
      @(negedge clock);
      if (run) begin
        hs_ar0 = m0_arvalid && m0_arready;
        hs_ar1 = m1_arvalid && m1_arready;
        hs_dar = out_arvalid && out_arready;
        hs_r   = out_rvalid && out_rready;
        cap_addr = out_araddr;
        cap_len  = out_arlen;
        @(posedge clock); #1;
        drive_master(0, hs_ar0);
        drive_master(1, hs_ar1);
        m0_rready = ($urandom % 10) < 7;
        m1_rready = ($urandom % 10) < 7;
        if (hs_r) begin
          dr_idx++;
          if (dr_idx >= dr_nb) dr_busy = 1'b0;
        end
        if (hs_dar) begin
          dr_busy = 1'b1; dr_addr = cap_addr; dr_idx = 0;
          dr_nb = plan_beats(cap_addr, cap_len);
        end
        out_arready = ($urandom % 3) != 0;
        if (!dr_busy) out_rvalid = 1'b0;
        else if (!(out_rvalid && !hs_r)) begin
          out_rvalid = ($urandom % 4) != 0;
          out_rdata  = beat_data(dr_addr, dr_idx);
          out_rresp  = dr_addr[5:4];
          out_rlast  = (dr_idx == dr_nb - 1);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : p_main
    bit got;
    int cyc;
    m0_araddr = '0; m0_arvalid = 0; m0_arlen = '0; m0_arsize = 3'd2; m0_arburst = 2'd1; m0_rready = 0;
    m1_araddr = '0; m1_arvalid = 0; m1_arlen = '0; m1_arsize = 3'd3; m1_arburst = 2'd2; m1_rready = 0;
    out_arready = 0; out_rvalid = 0; out_rdata = '0; out_rresp = '0; out_rlast = 0;
    issued[0] = 0; issued[1] = 0; gap[0] = 0; gap[1] = 0; done_cnt[0] = 0; done_cnt[1] = 0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ctrl", {out_arvalid, out_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast}, 64'd0);
    check("rst_data", {m0_rdata, m1_rdata}, 64'd0);
    check("rst_araddr", out_araddr, 64'd0);
    check("rst_err", err_beat, 64'd0);
    reset_n = 1'b1;

    // M0 burst of 8 at 0x8000_0040; reset pulled during its third beat.
    @(posedge clock); #1;
    m0_araddr = 32'h8000_0040; m0_arlen = 8'd7; m0_arvalid = 1'b1;
    out_arready = 1'b1; m0_rready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (m0_arready) got = 1'b1;
    end
    check("dir_ar_grant", got, 64'd1);
    check("dir_ar_fields", {out_araddr, out_arlen, out_arvalid}, {32'h8000_0040, 8'd7, 1'b1});
    @(posedge clock); #1;
    m0_arvalid = 1'b0; out_arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      out_rvalid = 1'b1; out_rdata = beat_data(32'h8000_0040, b); out_rlast = 1'b0;
      @(negedge clock);
      check("dir_beat", {m0_rvalid, m0_rdata, out_rready}, {1'b1, beat_data(32'h8000_0040, b), 1'b1});
      if (b < 2) begin
        @(posedge clock); #1;
      end
    end
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_outputs", {m0_rvalid, m0_rdata, m0_rlast, out_rready, out_arvalid, m0_arready}, 64'd0);
    check("async_rst_err", err_beat, 64'd0);
    out_rvalid = 1'b0; m0_rready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #2;
    run = 1'b1;

    cyc = 0;
    while (cyc < 20000 && !(done_cnt[0] == NTX && done_cnt[1] == NTX)) begin
      @(posedge clock);
      cyc++;
    end
    check("all_bursts_done", {done_cnt[0], done_cnt[1]}, {NTX, NTX});
    repeat (4) @(posedge clock);
    @(negedge clock); #2;
    check("queues_drained", q_ar.size() + q_b0.size() + q_b1.size(), 64'd0);
    check("err_final", err_beat, mb_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ysyx_23060025_axi_rd_arbiter
`default_nettype wire
